// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RAM arbiter.
//   - OWNER encodings (owner_t): OWN_NONE / OWN_H / OWN_D / OWN_I
//   - FSM state encoding (state_t): ST_IDLE / ST_ISSUE / ST_RESP
//   - Default address/data widths and one-hot grant bit positions.
package ram_arb_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 32;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_H = 0;
    localparam int GNT_D = 1;
    localparam int GNT_I = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_H    = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of the three requester ports, the RAM port and the
// status outputs of the RAM arbiter.
//   slave  modport : seen by the arbiter (requests in, acks/RAM port out).
//   master modport : seen by the SoC side (requesters and the RAM model).
// Requester ports: *_req, *_we (H/D only), *_addr, *_wdata (H/D only), *_ack.
// Shared: rdata (valid while an ack is high), owner, busy.
// RAM port: mem_en, mem_we, mem_addr, mem_wdata (registered), mem_rdata.
interface ram_arbiter_if
#(
    parameter int AW = ram_arb_pkg::AW_DEF,
    parameter int DW = ram_arb_pkg::DW_DEF
);
    logic          h_req, d_req, i_req;
    logic          h_we, d_we;
    logic [AW-1:0] h_addr, d_addr, i_addr;
    logic [DW-1:0] h_wdata, d_wdata;
    logic          h_ack, d_ack, i_ack;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner;
    logic          busy;

    modport slave (
        input  h_req, d_req, i_req, h_we, d_we,
        input  h_addr, d_addr, i_addr, h_wdata, d_wdata, mem_rdata,
        output h_ack, d_ack, i_ack, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, owner, busy
    );

    modport master (
        output h_req, d_req, i_req, h_we, d_we,
        output h_addr, d_addr, i_addr, h_wdata, d_wdata, mem_rdata,
        input  h_ack, d_ack, i_ack, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, owner, busy
    );

endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection among the H, D and I requests.
//   Inputs : h_req, d_req, i_req, and favor_i (rotation pointer, only when
//            ARB_RR_EN is defined; 1 = I wins a D/I tie).
//   Outputs: grant (one-hot, bit positions GNT_H/GNT_D/GNT_I), owner code.
// Build option ARB_RR_EN: H keeps absolute priority, D and I alternate on
// ties. Without it the order is strictly H > D > I.
module ram_arb_pick
    import ram_arb_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic       favor_i,
`endif
    input  logic       h_req,
    input  logic       d_req,
    input  logic       i_req,
    output logic [2:0] grant,
    output owner_t     owner
);

    logic d_wins;

`ifdef ARB_RR_EN
    assign d_wins = d_req && !(i_req && favor_i);
`else
    assign d_wins = d_req;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        grant = '0;
        owner = OWN_NONE;
        if (h_req) begin
            grant[GNT_H] = 1'b1;
            owner        = OWN_H;
        end else if (d_wins) begin
            grant[GNT_D] = 1'b1;
            owner        = OWN_D;
        end else if (i_req) begin
            grant[GNT_I] = 1'b1;
            owner        = OWN_I;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: sequences the shared synchronous RAM among the host (H),
// data-cache (D) and instruction-cache (I) requesters, one at a time.
//   clk  : system clock, rising edge.
//   res  : asynchronous active-low reset.
//   bus  : ram_arbiter_if.slave (requests, acks, rdata, RAM port, owner, busy).
// Each transaction takes IDLE -> ISSUE -> RESP: the MEM_* registers load on
// the IDLE grant edge, the RAM acts at the end of ISSUE, and the owner's ack
// plus read data appear during RESP.
// Build option ARB_RR_EN: D/I alternation through a rotation pointer.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)
(
    input  logic          clk,
    input  logic          res,
    ram_arbiter_if.slave  bus
);

    state_t        state, state_nxt;
    owner_t        owner_q, pick_owner;
    logic [2:0]    pick_grant;
    logic          op_we;   // remembers the operation after mem_we clears
    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef ARB_RR_EN
    logic          favor_i;  // 0 favours D, 1 favours I
`endif

    ram_arb_pick u_pick (
`ifdef ARB_RR_EN
        .favor_i (favor_i),
`endif
        .h_req   (bus.h_req),
        .d_req   (bus.d_req),
        .i_req   (bus.i_req),
        .grant   (pick_grant),
        .owner   (pick_owner)
    );

    // Route the winner's operation onto the capture path; I is read-only.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (pick_grant[GNT_H]) begin
            sel_we    = bus.h_we;
            sel_addr  = bus.h_addr;
            sel_wdata = bus.h_wdata;
        end else if (pick_grant[GNT_D]) begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end else if (pick_grant[GNT_I]) begin
            sel_addr  = bus.i_addr;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (|pick_grant) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= ST_IDLE;
            owner_q     <= OWN_NONE;
            op_we       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (|pick_grant) begin
                        owner_q     <= pick_owner;
                        op_we       <= sel_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
                ST_RESP: owner_q <= OWN_NONE;
                default: owner_q <= OWN_NONE;
            endcase
        end
    end

`ifdef ARB_RR_EN
    // Pointer moves only on D or I grants; H grants leave it alone.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            favor_i <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (pick_grant[GNT_D])      favor_i <= 1'b1;
            else if (pick_grant[GNT_I]) favor_i <= 1'b0;
        end
    end
`endif

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state != ST_IDLE);

    // Acks decode from the registered state, so an async reset drops them
    // immediately and an aborted transaction never acknowledges.
    assign bus.h_ack = (state == ST_RESP) && (owner_q == OWN_H);
    assign bus.d_ack = (state == ST_RESP) && (owner_q == OWN_D);
    assign bus.i_ack = (state == ST_RESP) && (owner_q == OWN_I);
    assign bus.rdata = (state == ST_RESP && !op_we) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter.
// Contains a behavioural synchronous RAM on the interface's RAM port and a
// preload path into that RAM model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;

    logic clk;
    logic res;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: one read/write port plus a bench preload port.
    logic [DW-1:0] ram [512];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Values captured by xact() during ISSUE and RESP.
    logic          iss_en, iss_we;
    logic [AW-1:0] iss_addr;
    logic [1:0]    iss_owner, resp_owner;

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic apply_reset();
        res = 1'b0;
        repeat (2) @(posedge clk);
        #1 res = 1'b1;
    endtask

    function automatic logic ack_of(input int who);
        case (who)
            1:       return bus.h_ack;
            2:       return bus.d_ack;
            default: return bus.i_ack;
        endcase
    endfunction

    // Issue one request from requester 'who' (1 H, 2 D, 3 I) just after an
    // edge N. lat = edge count after N at which the ack is seen (-1 = none).
    task automatic xact(input int who, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                        output int lat);
        lat = -1;
        rd  = 'x;
        case (who)
            1:       begin bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = a; bus.h_wdata = wd; end
            2:       begin bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; end
            default: begin bus.i_req = 1'b1; bus.i_addr = a; end
        endcase
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) begin
                iss_en = bus.mem_en; iss_we = bus.mem_we;
                iss_addr = bus.mem_addr; iss_owner = bus.owner;
            end
            if (ack_of(who)) begin
                lat = cyc; rd = bus.rdata; resp_owner = bus.owner;
                bus.h_req = 1'b0; bus.d_req = 1'b0; bus.i_req = 1'b0;
                break;
            end
        end
        bus.h_req = 1'b0; bus.d_req = 1'b0; bus.i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [DW-1:0] rd;
    int            lat;
    int            ack_at [3];
    int            seq [4];
    int            exp_seq [4];
    int            n_seq;
    logic          multi;
    logic          saw_ack;

    initial begin
        res = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.h_req = 1'b0; bus.d_req = 1'b0; bus.i_req = 1'b0;
        bus.h_we = 1'b0; bus.d_we = 1'b0;
        bus.h_addr = '0; bus.d_addr = '0; bus.i_addr = '0;
        bus.h_wdata = '0; bus.d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_acks",   32'({bus.h_ack, bus.d_ack, bus.i_ack}), 32'd0);
        check("rst_rdata",  bus.rdata, 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr",   32'(bus.mem_addr), 32'd0);
        check("rst_wdata",  bus.mem_wdata, 32'd0);
        check("rst_owner",  32'(bus.owner), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        @(posedge clk); #1 res = 1'b1;
        @(posedge clk); #1;

        // Single D read of preloaded word
        preload(9'd5, 32'hDEADBEEF);
        preload(9'd0, 32'hCAFE0000);
        xact(2, 1'b0, 9'd5, 32'h0, rd, lat);
        check("rd_iss_en",    32'(iss_en), 32'd1);
        check("rd_iss_we",    32'(iss_we), 32'd0);
        check("rd_iss_addr",  32'(iss_addr), 32'd5);
        check("rd_iss_owner", 32'(iss_owner), 32'd2);
        check("rd_latency",   32'(lat), 32'd2);
        check("rd_data",      rd, 32'hDEADBEEF);
        check("rd_resp_owner", 32'(resp_owner), 32'd2);
        check("rd_idle_busy", 32'(bus.busy), 32'd0);
        check("rd_idle_owner", 32'(bus.owner), 32'd0);

        // H write then I read of the top address
        xact(1, 1'b1, 9'h1FF, 32'h12345678, rd, lat);
        check("wr_iss_we",   32'(iss_we), 32'd1);
        check("wr_latency",  32'(lat), 32'd2);
        check("wr_rdata0",   rd, 32'd0);
        xact(3, 1'b0, 9'h1FF, 32'h0, rd, lat);
        check("ird_iss_addr", 32'(iss_addr), 32'h1FF);
        check("ird_latency", 32'(lat), 32'd2);
        check("ird_data",    rd, 32'h12345678);

        // Wrap: address 511 is reachable, then address 0 services normally
        xact(3, 1'b0, 9'd0, 32'h0, rd, lat);
        check("wrap0_latency", 32'(lat), 32'd2);
        check("wrap0_data",    rd, 32'hCAFE0000);

        // Simultaneous H, D, I -> acks at N+2, N+5, N+8 in H, D, I order
        ack_at = '{-1, -1, -1};
        multi  = 1'b0;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 9'd5;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'h1FF;
        bus.i_req = 1'b1; bus.i_addr = 9'd0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (int'(bus.h_ack) + int'(bus.d_ack) + int'(bus.i_ack) > 1) multi = 1'b1;
            if (bus.h_ack) begin ack_at[0] = cyc; bus.h_req = 1'b0; end
            if (bus.d_ack) begin ack_at[1] = cyc; bus.d_req = 1'b0; end
            if (bus.i_ack) begin ack_at[2] = cyc; bus.i_req = 1'b0; end
        end
        check("sim_h_at",  32'(ack_at[0]), 32'd2);
        check("sim_d_at",  32'(ack_at[1]), 32'd5);
        check("sim_i_at",  32'(ack_at[2]), 32'd8);
        check("sim_onehot", 32'(multi), 32'd0);
        @(posedge clk); #1;

        // Continuous D and I, pointer freshly reset (favours D)
        apply_reset();
        @(posedge clk); #1;
`ifdef ARB_RR_EN
        exp_seq = '{2, 3, 2, 3};
`else
        exp_seq = '{2, 2, 2, 2};
`endif
        seq   = '{0, 0, 0, 0};
        n_seq = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'd5;
        bus.i_req = 1'b1; bus.i_addr = 9'd0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (n_seq < 4 && bus.d_ack) begin seq[n_seq] = 2; n_seq++; end
            if (n_seq < 4 && bus.i_ack) begin seq[n_seq] = 3; n_seq++; end
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        for (int k = 0; k < 4; k++) check($sformatf("rr_ack%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
        repeat (4) @(posedge clk);
        #1;

        // Reset during ISSUE of a D write: no write, no ack, back to IDLE
        preload(9'd3, 32'h11111111);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 9'd3; bus.d_wdata = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        check("abort_pre_we", 32'(bus.mem_we), 32'd1);
        res = 1'b0;
        #1;
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_mem_en", 32'(bus.mem_en), 32'd0);
        check("abort_owner",  32'(bus.owner), 32'd0);
        check("abort_busy",   32'(bus.busy), 32'd0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 res = 1'b1;
        saw_ack = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus.d_ack) saw_ack = 1'b1;
        end
        check("abort_no_ack", 32'(saw_ack), 32'd0);
        check("abort_ram",    ram[3], 32'h11111111);
        check("abort_idle",   32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time bound so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
